pim_tile_dispatcher: RTL and testbench

- Issues matrix-multiply tile commands to a square grid of PIM units.
- Successor to the fixed-size partitioning: matrix size is a run-time input, up to a parametrised maximum.
- Per-unit credit flow control bounds the commands outstanding at each unit; completions are collected until all work drains.
- Sits between the top-level controller (start/done) and the PIM unit array (command bus plus completion returns).

---
 rtl/pim_tile_dispatcher.sv | 128 ++++++++++++
 tb/tb_pim_tile_dispatcher.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_tile_dispatcher.sv
// rtl/pim_tile_dispatcher.sv - issues k-major matmul tile commands to a PIM grid
// with per-unit credit flow control and completion draining.
module pim_tile_dispatcher #(
  parameter int NUM_UNITS       = 4,
  parameter int GRID            = 2,
  parameter int UNIT_CAPACITY   = 2,
  parameter int MAX_MATRIX_SIZE = 512,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SW              = $clog2(MAX_MATRIX_SIZE) + 1,
  parameter int AW              = $clog2(MAX_MATRIX_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [SW-1:0]                matrix_size,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         cmd_valid,
  input  logic [NUM_UNITS-1:0]         cmd_ready,
  output logic [$clog2(NUM_UNITS)-1:0] cmd_unit,
  output logic [AW-1:0]                cmd_row,
  output logic [AW-1:0]                cmd_col,
  output logic [AW-1:0]                cmd_k,
  input  logic [NUM_UNITS-1:0]         cpl_valid
);
  localparam int UW        = $clog2(NUM_UNITS);
  localparam int CW        = $clog2(MAX_OUTSTANDING + 1);
  localparam int STEP      = GRID * UNIT_CAPACITY;
  localparam bit GRID_POW2 = (GRID & (GRID - 1)) == 0;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [SW-1:0] n_reg;
  logic [AW-1:0] chunk;
  logic [AW-1:0] k_cnt;
  logic [UW-1:0] unit_cnt;
  logic [CW-1:0] credit     [NUM_UNITS];
  logic [CW-1:0] credit_nxt [NUM_UNITS];
  logic          err_q;
  logic          size_ok, accept, bad_start;
  logic          target_full, fire, last_cmd;
  logic          spurious, all_drained;

  assign size_ok   = (matrix_size != '0) && (matrix_size <= SW'(MAX_MATRIX_SIZE))
                   && ((32'(matrix_size) % STEP) == 0);
  assign accept    = (state == IDLE) && start && size_ok;
  assign bad_start = (state == IDLE) && start && !size_ok;

  // Strict in-order issue: a full target unit stalls the whole stream.
  assign target_full = credit[unit_cnt] == CW'(MAX_OUTSTANDING);
  assign fire        = cmd_valid && cmd_ready[unit_cnt];
  assign last_cmd    = (unit_cnt == UW'(NUM_UNITS - 1))
                     && ((SW'(k_cnt) + SW'(UNIT_CAPACITY)) == n_reg);

  // A completion against an empty counter is dropped and flagged.
  always_comb begin
    spurious    = 1'b0;
    all_drained = 1'b1;
    for (int u = 0; u < NUM_UNITS; u++) begin
      credit_nxt[u] = credit[u];
      if (cpl_valid[u] && (credit[u] == '0)) spurious = 1'b1;
      case ({fire && (unit_cnt == UW'(u)), cpl_valid[u] && (credit[u] != '0)})
        2'b10:   credit_nxt[u] = credit[u] + 1'b1;
        2'b01:   credit_nxt[u] = credit[u] - 1'b1;
        default: credit_nxt[u] = credit[u];
      endcase
      if (credit_nxt[u] != '0) all_drained = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (fire && last_cmd) state_nxt = DRAIN;
      DRAIN:   if (all_drained) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ISSUE) || (state == DRAIN);
    done      = (state == DONE);
    cmd_valid = (state == ISSUE) && !target_full;
  end

  assign err      = err_q;
  assign cmd_unit = unit_cnt;
  assign cmd_k    = k_cnt;
  assign cmd_row  = AW'(32'(unit_cnt) / GRID) * chunk;
  assign cmd_col  = AW'(32'(unit_cnt) % GRID) * chunk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg    <= '0;
      chunk    <= '0;
      k_cnt    <= '0;
      unit_cnt <= '0;
      err_q    <= 1'b0;
      for (int u = 0; u < NUM_UNITS; u++) credit[u] <= '0;
    end else begin
      err_q <= bad_start || spurious;
      for (int u = 0; u < NUM_UNITS; u++) credit[u] <= credit_nxt[u];
      if (accept) begin
        n_reg    <= matrix_size;
        chunk    <= AW'(GRID_POW2 ? (matrix_size >> $clog2(GRID))
                                  : SW'(32'(matrix_size) / GRID));
        k_cnt    <= '0;
        unit_cnt <= '0;
      end else if (fire) begin
        if (unit_cnt == UW'(NUM_UNITS - 1)) begin
          unit_cnt <= '0;
          k_cnt    <= last_cmd ? '0 : k_cnt + AW'(UNIT_CAPACITY);
        end else begin
          unit_cnt <= unit_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pim_tile_dispatcher.sv
// tb/tb_pim_tile_dispatcher.sv - self-checking bench for pim_tile_dispatcher.
module tb_pim_tile_dispatcher;
  localparam int NU = 4, GRID = 2, CAP = 2, MAXN = 512, MO = 4;
  localparam int SW = 10, AW = 9, UW = 2;

  typedef struct { int n; bit exp_err; int exp_cmds; } vec_t;
  typedef struct { int u; int row; int col; int k; } cmd_t;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [SW-1:0] matrix_size = '0;
  logic          busy, done, err, cmd_valid;
  logic [NU-1:0] cmd_ready = '0, cpl_valid = '0, cpl_pend = '0;
  logic [UW-1:0] cmd_unit;
  logic [AW-1:0] cmd_row, cmd_col, cmd_k;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  pim_tile_dispatcher #(
    .NUM_UNITS(NU), .GRID(GRID), .UNIT_CAPACITY(CAP), .MAX_MATRIX_SIZE(MAXN),
    .MAX_OUTSTANDING(MO), .SW(SW), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .matrix_size(matrix_size),
    .busy(busy), .done(done), .err(err), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_unit(cmd_unit), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .cmd_k(cmd_k), .cpl_valid(cpl_valid)
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, cmd_valid, 0);
    check({tag, "_unit"}, cmd_unit, 0);
    check({tag, "_row"}, cmd_row, 0);
    check({tag, "_col"}, cmd_col, 0);
    check({tag, "_k"}, cmd_k, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; cmd_ready = '0; cpl_valid = '0; cpl_pend = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_job(input int n);
    @(negedge clk);
    matrix_size = n[SW-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Responder-driven cycle: applies pending completions, records any transfer.
  task automatic tick(input logic [NU-1:0] mask, output bit fired, output int fu);
    cpl_valid = cpl_pend;
    cpl_pend  = '0;
    fired = cmd_valid && cmd_ready[cmd_unit];
    fu    = int'(cmd_unit);
    if (fired && mask[cmd_unit]) cpl_pend[cmd_unit] = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_illegal(input int n);
    start_job(n);
    check("bad_err_pulse", err, 1);
    check("bad_busy", busy, 0);
    check("bad_valid", cmd_valid, 0);
    @(negedge clk);
    check("bad_err_clear", err, 0);
    check("bad_busy2", busy, 0);
    check("bad_valid2", cmd_valid, 0);
  endtask

  // Reference: expected command list from the loop nest, outstanding counts per unit.
  task automatic run_job(input int n, input int ready_pct, input int cpl_pct, input int exp_cmds);
    cmd_t q[$];
    int   outst[NU];
    int   idx, xfers, cyc, chunk, tgt;
    bit   done_next, finished, exp_issue, exp_valid, drained;
    chunk = n / GRID;
    for (int k = 0; k < n; k += CAP)
      for (int u = 0; u < NU; u++)
        q.push_back('{u, (u / GRID) * chunk, (u % GRID) * chunk, k});
    foreach (outst[i]) outst[i] = 0;
    idx = 0; xfers = 0; cyc = 0; done_next = 0; finished = 0;
    cmd_ready = '0; cpl_valid = '0;
    start_job(n);
    while (!finished && cyc < 20000) begin
      exp_issue = idx < q.size();
      exp_valid = 1'b0;
      tgt = 0;
      if (exp_issue) begin
        tgt = q[idx].u;
        exp_valid = outst[tgt] < MO;
      end
      check("busy", busy, !done_next);
      check("done", done, done_next);
      check("err", err, 0);
      check("cmd_valid", cmd_valid, exp_valid);
      if (exp_issue) begin
        check("cmd_unit", cmd_unit, q[idx].u);
        check("cmd_row", cmd_row, q[idx].row);
        check("cmd_col", cmd_col, q[idx].col);
        check("cmd_k", cmd_k, q[idx].k);
      end
      if (done_next) finished = 1'b1;
      for (int u = 0; u < NU; u++) begin
        cmd_ready[u] = $urandom_range(0, 99) < ready_pct;
        cpl_valid[u] = (outst[u] > 0) && ($urandom_range(0, 99) < cpl_pct);
      end
      if (cmd_valid && cmd_ready[cmd_unit]) xfers++;
      if (exp_valid && cmd_ready[tgt]) begin
        outst[tgt]++;
        idx++;
      end
      drained = 1'b1;
      for (int u = 0; u < NU; u++) begin
        if (cpl_valid[u]) outst[u]--;
        if (outst[u] != 0) drained = 1'b0;
      end
      if (!done_next && !finished && idx == q.size() && drained) done_next = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (!finished) check("job_timeout", 0, 1);
    cmd_ready = '0; cpl_valid = '0;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("xfer_count", xfers, exp_cmds);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    bit   f;
    int   fu, u0, errs, rec_row, rec_col, rec_k;
    vecs = '{'{4, 0, 8}, '{0, 1, 0}, '{6, 1, 0}, '{514, 1, 0}, '{8, 0, 16},
             '{510, 1, 0}, '{12, 0, 24}, '{513, 1, 0}, '{512, 0, 1024}};

    #12;
    check_idle_outputs("reset");
    check("reset_err", err, 0);
    do_reset();

    foreach (vecs[i]) begin
      if (vecs[i].exp_err) run_illegal(vecs[i].n);
      else                 run_job(vecs[i].n, 100, 100, vecs[i].exp_cmds);
    end

    for (int j = 0; j < 6; j++) begin
      int n;
      n = STEP_N(int'($urandom_range(1, 16)));
      run_job(n, int'($urandom_range(50, 100)), int'($urandom_range(30, 90)), NU * n / CAP);
    end

    // Credit stall: unit 0 never completes on its own.
    do_reset();
    cmd_ready = '1;
    start_job(16);
    u0 = 0;
    repeat (40) begin tick(4'b1110, f, fu); if (f && fu == 0) u0++; end
    check("stall_u0_count", u0, 4);
    check("stall_valid", cmd_valid, 0);
    check("stall_unit", cmd_unit, 0);
    check("stall_k", cmd_k, 8);
    check("stall_busy", busy, 1);
    cpl_pend[0] = 1'b1;
    repeat (20) begin tick(4'b1110, f, fu); if (f && fu == 0) u0++; end
    check("credit_u0_count", u0, 5);
    check("credit_valid", cmd_valid, 0);
    check("credit_unit", cmd_unit, 0);
    check("credit_k", cmd_k, 10);

    // Asynchronous reset while issuing, then a fresh job from k=0.
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_err", err, 0);
    cpl_pend = '0; cpl_valid = '0; cmd_ready = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_job(8, 100, 100, 16);

    // Backpressure on unit 1.
    do_reset();
    cmd_ready = '1;
    start_job(8);
    for (int i = 0; i < 10 && !(cmd_valid && cmd_unit == 1); i++) tick(4'b1111, f, fu);
    check("bp_found", cmd_valid && cmd_unit == 1, 1);
    rec_row = int'(cmd_row); rec_col = int'(cmd_col); rec_k = int'(cmd_k);
    cmd_ready[1] = 1'b0;
    repeat (5) begin
      tick(4'b1111, f, fu);
      check("bp_no_xfer", f, 0);
      check("bp_valid", cmd_valid, 1);
      check("bp_unit", cmd_unit, 1);
      check("bp_row", cmd_row, rec_row);
      check("bp_col", cmd_col, rec_col);
      check("bp_k", cmd_k, rec_k);
    end
    cmd_ready[1] = 1'b1;
    tick(4'b1111, f, fu);
    check("bp_release_xfer", f && fu == 1, 1);
    check("bp_next_unit", cmd_unit, 2);

    // Transfer and completion on unit 2 in the same cycle leave its count unchanged.
    do_reset();
    cmd_ready = '1;
    start_job(16);
    errs = 0;
    repeat (60) begin
      if (cmd_valid && cmd_unit == 2 && cmd_k == 2) cpl_pend[2] = 1'b1;
      tick(4'b1011, f, fu);
      errs += int'(err);
    end
    check("simul_valid", cmd_valid, 0);
    check("simul_unit", cmd_unit, 2);
    check("simul_k", cmd_k, 10);
    check("simul_no_err", errs, 0);

    // Spurious completion in IDLE.
    do_reset();
    cpl_valid = 4'b1000;
    @(negedge clk);
    cpl_valid = '0;
    check("spur_err", err, 1);
    check("spur_busy", busy, 0);
    check("spur_valid", cmd_valid, 0);
    check("spur_done", done, 0);
    @(negedge clk);
    check("spur_err_clear", err, 0);
    run_job(4, 100, 100, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic int STEP_N(input int m);
    return m * GRID * CAP;
  endfunction
endmodule
